// File: rtl/xbus_unibus_ctl_if.sv
// Xbus request port plus the Unibus side-band signals seen by the adapter controller.
// The controller uses the slave modport; the requester, arbiter and interrupt sources use master.
interface xbus_unibus_ctl_if #(
    parameter int NINT = 4
);
    logic [21:0]     addr;
    logic [31:0]     datain;
    logic            req;
    logic            write;
    logic            timeout;
    logic [NINT-1:0] irq_in;
    logic [31:0]     dataout;
    logic            ack;
    logic            decode;
    logic            interrupt;
    logic            promdisable;

    modport master (
        output addr, datain, req, write, timeout, irq_in,
        input  dataout, ack, decode, interrupt, promdisable
    );

    modport slave (
        input  addr, datain, req, write, timeout, irq_in,
        output dataout, ack, decode, interrupt, promdisable
    );
endinterface

// File: rtl/xbus_unibus_ctl.sv
// Unibus/Xbus adapter controller: register window decode, delayed ack, prioritised
// Unibus interrupt controller, first-error NXM capture and sticky PROM disable.
//
// Interrupt FSM:
//   state     | meaning
//   S_IDLE    | no source latched; lowest pending & unmasked source latched next
//   S_LATCHED | source cur latched, vector valid; left only by an offset-20 write
module xbus_unibus_ctl #(
    parameter logic [21:0] UBASE    = 22'o17773000,
    parameter int          NINT     = 4,
    parameter logic [7:0]  VEC_BASE = 8'o140,
    parameter int          ACK_DLY  = 2,
    parameter logic [21:0] UB_LIMIT = 22'o17400000,
    parameter logic [21:0] XB_LIMIT = 22'o17000000
) (
    input logic              clk,
    input logic              reset,
    xbus_unibus_ctl_if.slave bus
);
    localparam int          CUR_W     = (NINT > 1) ? $clog2(NINT) : 1;
    localparam logic [21:0] OTHER_A   = 22'o17777700;
    localparam logic [21:0] OTHER_B   = 22'o17740000;
    localparam logic [0:0]  S_IDLE    = 1'b0;
    localparam logic [0:0]  S_LATCHED = 1'b1;

    logic               in_ub;
    logic               in_other;
    logic               decode;
    logic               decode_ub;
    logic               decode_q;
    logic               wr_first;
    logic               wr05;
    logic               wr20;
    logic               wr22;
    logic               wr24;
    logic [5:0]         offset;
    logic [ACK_DLY-1:0] ack_pipe;
    logic [31:0]        rd_data;

    logic [0:0]         state;
    logic               unibus_int;
    logic               xbus_int;
    logic               int_en;
    logic [NINT-1:0]    pending;
    logic [NINT-1:0]    mask;
    logic [NINT-1:0]    active;
    logic [NINT-1:0]    clr_mask;
    logic [CUR_W-1:0]   cur;
    logic [CUR_W-1:0]   lo_idx;
    logic [7:0]         vector;

    logic               unibus_nxm;
    logic               xbus_nxm;
    logic [21:0]        nxm_addr;
    logic               to_ub;
    logic               to_xb;
    logic               ub_nxm_c;
    logic               xb_nxm_c;

    assign offset    = bus.addr[5:0];
    assign in_ub     = bus.addr[21:6] == UBASE[21:6];
    assign in_other  = (bus.addr[21:6] == OTHER_A[21:6]) | (bus.addr[21:12] == OTHER_B[21:12]);
    assign decode    = bus.req & (in_ub | in_other);
    assign decode_ub = bus.req & in_ub;
    assign bus.decode = decode;
    assign bus.ack    = ack_pipe[ACK_DLY-1];

    // A held request produces exactly one register write, on its first decode cycle.
    assign wr_first = decode_ub & bus.write & ~decode_q;
    assign wr05     = wr_first & (offset == 6'o05);
    assign wr20     = wr_first & (offset == 6'o20);
    assign wr22     = wr_first & (offset == 6'o22);
    assign wr24     = wr_first & (offset == 6'o24);

    always_ff @(posedge clk) begin
        if (reset) begin
            ack_pipe <= '0;
            decode_q <= 1'b0;
        end else begin
            ack_pipe[0] <= decode;
            for (int i = 1; i < ACK_DLY; i++) begin
                ack_pipe[i] <= ack_pipe[i-1];
            end
            decode_q <= decode;
        end
    end

    always_comb begin
        rd_data = '0;
        case (offset)
            6'o20: rd_data = {16'b0, unibus_int, xbus_int, 3'b0, int_en, vector, 2'b0};
            6'o22: rd_data = {28'b0, unibus_nxm, 2'b0, xbus_nxm};
            6'o24: begin
                rd_data[31:16] = 16'(pending);
                rd_data[15:0]  = 16'(mask);
            end
            6'o26: rd_data = {10'b0, nxm_addr};
            default: rd_data = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.dataout     <= '0;
            bus.promdisable <= 1'b0;
        end else begin
            bus.dataout <= (decode_ub & ~bus.write) ? rd_data : '0;
            if (wr05 & bus.datain[5] & bus.datain[2] & ~bus.datain[0]) begin
                bus.promdisable <= 1'b1;
            end
        end
    end

    assign xbus_int   = 1'b0;
    assign unibus_int = (state == S_LATCHED);
    assign active     = pending & mask;
    assign clr_mask   = wr20 ? (NINT'(1) << cur) : '0;

    always_comb begin
        lo_idx = '0;
        for (int i = NINT - 1; i >= 0; i--) begin
            if (active[i]) lo_idx = CUR_W'(i);
        end
    end

    // A new irq_in bit in the clear cycle survives because the OR follows the clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= S_IDLE;
            pending       <= '0;
            mask          <= '0;
            int_en        <= 1'b0;
            cur           <= '0;
            vector        <= '0;
            bus.interrupt <= 1'b0;
        end else begin
            pending <= (pending & ~clr_mask) | bus.irq_in;
            if (wr24) mask <= bus.datain[NINT-1:0];
            if (wr20) begin
                int_en <= bus.datain[10];
                state  <= S_IDLE;
                vector <= '0;
            end else if ((state == S_IDLE) && (|active)) begin
                cur    <= lo_idx;
                vector <= VEC_BASE + 8'({lo_idx, 2'b00});
                state  <= S_LATCHED;
            end
            bus.interrupt <= unibus_int & int_en;
        end
    end

    assign to_ub    = bus.timeout & (bus.addr > UB_LIMIT);
    assign to_xb    = bus.timeout & ~(bus.addr > UB_LIMIT) & (bus.addr > XB_LIMIT);
    assign ub_nxm_c = unibus_nxm & ~wr22;
    assign xb_nxm_c = xbus_nxm & ~wr22;

    // Clear is applied first so a same-cycle timeout is captured as a fresh first error.
    always_ff @(posedge clk) begin
        if (reset) begin
            unibus_nxm <= 1'b0;
            xbus_nxm   <= 1'b0;
            nxm_addr   <= '0;
        end else begin
            unibus_nxm <= ub_nxm_c | to_ub;
            xbus_nxm   <= xb_nxm_c | to_xb;
            if ((to_ub | to_xb) & ~ub_nxm_c & ~xb_nxm_c) begin
                nxm_addr <= bus.addr;
            end else if (wr22) begin
                nxm_addr <= '0;
            end
        end
    end
endmodule

// File: tb/tb_xbus_unibus_ctl.sv
// Directed bench for xbus_unibus_ctl: decode/ack latency at ACK_DLY 1/2/4, register
// file, interrupt priority and vectors, NXM capture and reset behaviour.
module tb_xbus_unibus_ctl;
    logic clk;
    logic reset;
    int   checks;
    int   failures;

    xbus_unibus_ctl_if #(.NINT(4)) bus  ();
    xbus_unibus_ctl_if #(.NINT(4)) bus1 ();
    xbus_unibus_ctl_if #(.NINT(4)) bus4 ();

    assign bus1.addr    = bus.addr;
    assign bus1.datain  = bus.datain;
    assign bus1.req     = bus.req;
    assign bus1.write   = bus.write;
    assign bus1.timeout = bus.timeout;
    assign bus1.irq_in  = bus.irq_in;
    assign bus4.addr    = bus.addr;
    assign bus4.datain  = bus.datain;
    assign bus4.req     = bus.req;
    assign bus4.write   = bus.write;
    assign bus4.timeout = bus.timeout;
    assign bus4.irq_in  = bus.irq_in;

    xbus_unibus_ctl #(.NINT(4), .ACK_DLY(2)) dut  (.clk(clk), .reset(reset), .bus(bus));
    xbus_unibus_ctl #(.NINT(4), .ACK_DLY(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
    xbus_unibus_ctl #(.NINT(4), .ACK_DLY(4)) dut4 (.clk(clk), .reset(reset), .bus(bus4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [21:0] UB = 22'o17773000;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Entered and left at posedge+1; drains all ack pipes before returning.
    task automatic bus_op(input logic [21:0] a, input logic w, input logic [31:0] d,
                          input logic to, output logic [31:0] rd);
        int n;
        logic got;
        bus.addr = a; bus.write = w; bus.datain = d; bus.timeout = to; bus.req = 1'b1;
        n = 0; got = 1'b0; rd = '0;
        while (!got && n < 20) begin
            @(posedge clk); #1;
            bus.timeout = 1'b0;
            n++;
            if (bus.ack) begin
                got = 1'b1;
                rd = bus.dataout;
            end
        end
        check("ack_seen", {31'b0, got}, 32'd1);
        bus.req = 1'b0; bus.write = 1'b0;
        repeat (6) @(posedge clk);
        #1;
    endtask

    task automatic pulse_irq(input logic [3:0] v);
        bus.irq_in = v;
        @(posedge clk); #1;
        bus.irq_in = '0;
    endtask

    task automatic pulse_timeout(input logic [21:0] a);
        bus.addr = a; bus.timeout = 1'b1;
        @(posedge clk); #1;
        bus.timeout = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        logic [31:0] d2;
        int lat1, lat2, lat4;
        checks = 0; failures = 0;
        reset = 1'b1;
        bus.addr = '0; bus.datain = '0; bus.req = 1'b0; bus.write = 1'b0;
        bus.timeout = 1'b0; bus.irq_in = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        check("rst_dataout", bus.dataout, 32'd0);
        check("rst_ack", {31'b0, bus.ack}, 32'd0);
        check("rst_interrupt", {31'b0, bus.interrupt}, 32'd0);
        check("rst_promdisable", {31'b0, bus.promdisable}, 32'd0);

        // Held read of offset 20: latency at all three ACK_DLY settings.
        bus.addr = UB + 22'o20; bus.write = 1'b0; bus.req = 1'b1;
        #1;
        check("decode_same_cycle", {31'b0, bus.decode}, 32'd1);
        check("ack_not_yet", {31'b0, bus.ack}, 32'd0);
        lat1 = 0; lat2 = 0; lat4 = 0; d2 = 32'hdead_beef;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            if (bus1.ack && lat1 == 0) lat1 = k;
            if (bus.ack && lat2 == 0) begin lat2 = k; d2 = bus.dataout; end
            if (bus4.ack && lat4 == 0) lat4 = k;
        end
        check("lat_dly2", lat2, 32'd2);
        check("lat_dly1", lat1, 32'd1);
        check("lat_dly4", lat4, 32'd4);
        check("rd20_after_reset", d2, 32'd0);
        bus.req = 1'b0;
        repeat (6) @(posedge clk);
        #1;

        bus_op(22'o17777700, 1'b0, 32'd0, 1'b0, rd);
        check("rd_other", rd, 32'd0);
        check("no_decode_idle", {31'b0, bus.decode}, 32'd0);

        bus_op(UB + 22'o05, 1'b1, 32'o45, 1'b0, rd);
        check("prom_o45", {31'b0, bus.promdisable}, 32'd0);
        bus_op(UB + 22'o05, 1'b1, 32'o44, 1'b0, rd);
        check("prom_o44_sticky", {31'b0, bus.promdisable}, 32'd1);

        // Interrupts: enable, unmask all, pulse sources 1 and 3.
        bus_op(UB + 22'o20, 1'b1, 32'h400, 1'b0, rd);
        bus_op(UB + 22'o24, 1'b1, 32'hF, 1'b0, rd);
        check("no_int_before_irq", {31'b0, bus.interrupt}, 32'd0);
        pulse_irq(4'b1010);
        repeat (3) @(posedge clk);
        #1;
        check("int_src1", {31'b0, bus.interrupt}, 32'd1);
        bus_op(UB + 22'o20, 1'b0, 32'd0, 1'b0, rd);
        check("rd20_vec144", rd, 32'h0000_8590);
        bus_op(UB + 22'o20, 1'b1, 32'h400, 1'b0, rd);
        bus_op(UB + 22'o20, 1'b0, 32'd0, 1'b0, rd);
        check("rd20_vec154", rd, 32'h0000_85B0);
        check("int_src3", {31'b0, bus.interrupt}, 32'd1);

        bus_op(UB + 22'o20, 1'b1, 32'h400, 1'b0, rd);
        bus_op(UB + 22'o24, 1'b1, 32'h1, 1'b0, rd);
        pulse_irq(4'b0100);
        repeat (3) @(posedge clk);
        #1;
        check("masked_no_int", {31'b0, bus.interrupt}, 32'd0);
        bus_op(UB + 22'o24, 1'b0, 32'd0, 1'b0, rd);
        check("rd24_pending4", rd, 32'h0004_0001);
        bus_op(UB + 22'o24, 1'b1, 32'h4, 1'b0, rd);
        bus_op(UB + 22'o20, 1'b0, 32'd0, 1'b0, rd);
        check("rd20_vec150", rd, 32'h0000_85A0);
        check("int_src2", {31'b0, bus.interrupt}, 32'd1);
        bus_op(UB + 22'o24, 1'b1, 32'h0, 1'b0, rd);
        check("mask_keeps_latched", {31'b0, bus.interrupt}, 32'd1);

        // NXM capture.
        pulse_timeout(22'o17773100);
        pulse_timeout(22'o17100000);
        pulse_timeout(22'o16000000);
        bus_op(UB + 22'o22, 1'b0, 32'd0, 1'b0, rd);
        check("nxm_status", rd, 32'o11);
        bus_op(UB + 22'o26, 1'b0, 32'd0, 1'b0, rd);
        check("nxm_addr_first", rd, {10'b0, 22'o17773100});
        bus_op(UB + 22'o22, 1'b1, 32'd0, 1'b0, rd);
        bus_op(UB + 22'o22, 1'b0, 32'd0, 1'b0, rd);
        check("nxm_cleared", rd, 32'd0);
        bus_op(UB + 22'o26, 1'b0, 32'd0, 1'b0, rd);
        check("nxm_addr_cleared", rd, 32'd0);
        bus_op(UB + 22'o22, 1'b1, 32'd0, 1'b1, rd);
        bus_op(UB + 22'o22, 1'b0, 32'd0, 1'b0, rd);
        check("nxm_timeout_wins", rd, 32'o10);
        bus_op(UB + 22'o26, 1'b0, 32'd0, 1'b0, rd);
        check("nxm_addr_new", rd, {10'b0, UB + 22'o22});

        // Reset with the ack pipe full and request held.
        bus.addr = UB + 22'o24; bus.write = 1'b0; bus.req = 1'b1;
        lat2 = 0;
        for (int k = 1; k <= 6 && lat2 == 0; k++) begin
            @(posedge clk); #1;
            if (bus.ack) begin lat2 = k; d2 = bus.dataout; end
        end
        check("pre_reset_ack", lat2, 32'd2);
        check("pre_reset_rd24", d2, 32'h0004_0000);
        reset = 1'b1;
        @(posedge clk); #1;
        check("reset_ack_low", {31'b0, bus.ack}, 32'd0);
        check("reset_dataout", bus.dataout, 32'd0);
        check("reset_interrupt", {31'b0, bus.interrupt}, 32'd0);
        check("reset_promdisable", {31'b0, bus.promdisable}, 32'd0);
        reset = 1'b0;
        lat2 = 0;
        for (int k = 1; k <= 6 && lat2 == 0; k++) begin
            @(posedge clk); #1;
            if (bus.ack) begin lat2 = k; d2 = bus.dataout; end
        end
        check("reack_latency", lat2, 32'd2);
        check("reack_rd24_zero", d2, 32'd0);
        bus.req = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        bus_op(UB + 22'o22, 1'b0, 32'd0, 1'b0, rd);
        check("reset_nxm", rd, 32'd0);
        bus_op(UB + 22'o26, 1'b0, 32'd0, 1'b0, rd);
        check("reset_nxm_addr", rd, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/xbus_unibus_ctl.md
Name: xbus_unibus_ctl

Overview:
- Parametrised Unibus/Xbus adapter controller: address decode, delayed ack and the bus status/interrupt register file for the processor's xbus request port.
- Adds an NINT-source prioritised Unibus interrupt controller with mask and vector generation.
- Adds first-error NXM address capture and a sticky PROM-disable control.
- Sits beside the xbus memory/IO slaves; consumes the bus-timeout strobe from the xbus arbiter.

Parameters:
- UBASE, 22'o17773000: Unibus register window base (64 words, offset = addr[5:0]).
- NINT, 4: number of Unibus interrupt sources (1..16).
- VEC_BASE, 8'o140: vector of source 0; source i gets VEC_BASE + 4*i, modulo 256.
- ACK_DLY, 2: cycles from decode to ack (>=1).
- UB_LIMIT, 22'o17400000: addresses above this time out as Unibus NXM.
- XB_LIMIT, 22'o17000000: addresses above this, and not above UB_LIMIT, time out as Xbus NXM.

Ports:
- clk in 1: clock.
- reset in 1: synchronous, active-high reset.
- addr in 22: request address.
- datain in 32: write data.
- req in 1: request; requester holds req/addr/write/datain until ack.
- write in 1: 1 = write, 0 = read.
- timeout in 1: one-cycle bus timeout strobe for the current addr.
- irq_in in NINT: Unibus interrupt requests, level or pulse.
- dataout out 32: registered read data.
- ack out 1: request done.
- decode out 1: address claimed (combinational).
- interrupt out 1: interrupt to processor.
- promdisable out 1: PROM disable.

Behaviour:
- Reset values: dataout=0, ack=0, interrupt=0, promdisable=0. Also cleared: pending, mask, int_en, unibus_int, vector, nxm flags, nxm_addr, ack pipe. xbus_int is always 0.
- Decode: in_ub = addr[21:6]==UBASE[21:6]. in_other = addr[21:6]==17777700[21:6] or addr[21:12]==17740000[21:12]. decode = req & (in_ub|in_other).
- Ack: ACK_DLY-deep shift of decode; ack = last stage, so ack rises exactly ACK_DLY cycles after decode rises. A req dropped mid-pipe flushes naturally.
- Writes take effect once, on the first decode cycle (decode & ~decode_q).
- Reads: dataout is registered every cycle with decode_ub & ~write, else 0. in_other reads return 0, and in_other writes are ignored.
- Offset 05 write: if datain[5]&datain[2]&~datain[0], promdisable <= 1. It is sticky until reset.
- Offset 20 read: {16'b0, unibus_int, xbus_int, 3'b0, int_en, vector, 2'b0}.
- Offset 20 write: int_en <= datain[10]; unibus_int <= 0; vector <= 0; pending[cur] <= 0, where cur is the latched source index.
- Offset 22 read: {28'b0, unibus_nxm, 2'b0, xbus_nxm}.
- Offset 22 write: clear unibus_nxm, xbus_nxm and nxm_addr.
- Offset 24 read: {pending (zero-extended to 16), mask (zero-extended to 16)}.
- Offset 24 write: mask <= datain[NINT-1:0].
- Offset 26 read: {10'b0, nxm_addr}. Offset 26 is read-only.
- Other offsets read 0; writes to them are ignored.
- Interrupt states, IDLE (unibus_int=0) and LATCHED (unibus_int=1):
  - Every cycle pending <= pending | irq_in.
  - IDLE: if |(pending & mask), latch the lowest set index i as cur, set vector = VEC_BASE+4*i, go to LATCHED on the next cycle.
  - LATCHED: leave only on an offset-20 write.
- interrupt = unibus_int & int_en, registered.
- Simultaneous irq_in[i] with an offset-20 clear of cur=i: set wins and pending stays 1. Re-latch happens no earlier than the cycle after the clear.
- Mask change never drops an already-latched interrupt.
- NXM on timeout:
  - addr > UB_LIMIT sets unibus_nxm; else addr > XB_LIMIT sets xbus_nxm; else no effect.
  - nxm_addr loads addr only if both flags were 0 (first error kept).
  - Timeout in the same cycle as an offset-22 clear: timeout wins, so the flag is set and nxm_addr = new addr.
- Reset mid-request forces ack low at once; the held request re-acks ACK_DLY cycles after reset deasserts.

Test Plan:
- Read 22'o17773020 held: decode same cycle, ack at +2 (ACK_DLY=2), dataout=0 after reset. Read 22'o17777700 -> ack, dataout 0.
- Write offset 05 datain=32'o44: promdisable=1 and stays 1 after req drops. Datain=32'o45 does not set it.
- irq_in=4'b1010 one cycle, mask=4'hF, write offset 20 datain bit10=1:
  - interrupt=1, offset 20 read vector field = 8'o144 (source 1).
  - Write offset 20 again -> source 3 latched, vector 8'o154.
- mask=4'b0001 with irq_in[2] pulsed: no interrupt; offset 24 reads pending=4. Then mask=4'b0100 -> vector 8'o150.
- Timeout at 22'o17773100 then at 22'o17100000: status reads 32'o11, offset 26 = 17773100. Write offset 22 -> status 0. Timeout during that clear cycle -> flag remains set.
- Assert reset with ack pipe full: ack=0 next cycle, all registers at reset values. Sweep ACK_DLY=1 and 4 for latency.
